iter_mul: RTL and testbench



---
 rtl/iter_mul.sv | 135 +++++++++++++
 tb/tb_iter_mul.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/iter_mul.sv
// Iterative radix-2 shift-add multiplier.
//
// Produces the full 2*data_width_p-bit product of two operands, either both
// unsigned or both two's-complement, one multiplier bit per cycle. It uses the
// same valid/ready/yumi handshake as the non-restoring divider, so both units
// can share the execute-stage issue and writeback path.
//
// Ports:
//   clk_i      clock, all state changes on the rising edge
//   reset_n_i  asynchronous active-low reset
//   signed_i   1: operands are two's-complement, 0: unsigned (sampled with v_i)
//   v_i        operand valid
//   a_i        multiplicand
//   b_i        multiplier
//   ready_o    unit is idle and can accept an operation
//   v_o        result valid, held until yumi_i
//   yumi_i     consumer takes the result (only meaningful while v_o=1)
//   hi_o       product bits [2W-1:W]
//   lo_o       product bits [W-1:0]
module iter_mul #(
  parameter int unsigned data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    signed_i,
  input  logic                    v_i,
  input  logic [data_width_p-1:0] a_i,
  input  logic [data_width_p-1:0] b_i,
  output logic                    ready_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic [data_width_p-1:0] hi_o,
  output logic [data_width_p-1:0] lo_o
);

  localparam int unsigned W    = data_width_p;
  localparam int unsigned W2   = 2 * data_width_p;
  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state;
  logic [W-1:0]      mcand;   // |a|
  logic [W-1:0]      mplier;  // |b|, shifted right so bit 0 is the current bit
  logic [W2-1:0]     acc;
  logic              neg;     // final product must be negated
  logic [CntW-1:0]   count;
  logic              ready;
  logic              v;
  logic [W-1:0]      hi;
  logic [W-1:0]      lo;

  logic [W-1:0]      a_abs;
  logic [W-1:0]      b_abs;
  logic              neg_in;
  logic [W:0]        partial;
  logic [W2-1:0]     acc_next;
  logic [W2-1:0]     prod;
  logic              last;

  always_comb begin
    // The most-negative operand negates to itself, which is exactly 2^(W-1)
    // when read as unsigned, so no extra bit is needed.
    a_abs  = (signed_i && a_i[W-1]) ? (~a_i + W'(1)) : a_i;
    b_abs  = (signed_i && b_i[W-1]) ? (~b_i + W'(1)) : b_i;
    neg_in = signed_i & (a_i[W-1] ^ b_i[W-1]);

    // The carry out of the upper-half add becomes the new MSB after the shift.
    partial  = {1'b0, acc[W2-1:W]} + {1'b0, (mplier[0] ? mcand : '0)};
    acc_next = {partial, acc[W-1:1]};

    prod = neg ? (~acc_next + W2'(1)) : acc_next;
    last = (count == CntW'(W - 1));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= StIdle;
      count  <= '0;
      ready  <= 1'b1;
      v      <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (v_i && ready) begin
            mcand  <= a_abs;
            mplier <= b_abs;
            neg    <= neg_in;
            acc    <= '0;
            count  <= '0;
            ready  <= 1'b0;
            state  <= StCalc;
          end
        end
        StCalc: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          if (last) begin
            {hi, lo} <= prod;
            count    <= '0;
            v        <= 1'b1;
            state    <= StDone;
          end else begin
            count <= count + CntW'(1);
          end
        end
        StDone: begin
          // hi/lo are left alone so they keep the last result after yumi.
          if (yumi_i) begin
            v     <= 1'b0;
            ready <= 1'b1;
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
          ready <= 1'b1;
          v     <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready;
  assign v_o     = v;
  assign hi_o    = hi;
  assign lo_o    = lo;

endmodule

// File: tb/tb_iter_mul.sv
// Self-checking bench for iter_mul (data_width_p = 32): directed corner
// products, handshake timing, asynchronous reset mid-operation, and random
// signed/unsigned products against a plain 64-bit multiply.
module tb_iter_mul;

  logic        clk_i;
  logic        reset_n_i;
  logic        signed_i;
  logic        v_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        ready_o;
  logic        v_o;
  logic        yumi_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  iter_mul #(.data_width_p(32)) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .signed_i (signed_i),
    .v_i      (v_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .yumi_i   (yumi_i),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle. Runs one operation end to end,
  // optionally stalling the consumer for 'hold' cycles before yumi.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input int hold, input string tag);
    int k;
    bit seen;
    bit ready_bad;
    check({tag, " ready_idle"}, {63'b0, ready_o}, 64'd1);
    v_i      = 1'b1;
    a_i      = a;
    b_i      = b;
    signed_i = s;
    @(posedge clk_i);
    #1;
    // Operands may change freely once accepted.
    v_i      = 1'b0;
    a_i      = ~a;
    b_i      = b ^ 32'h5A5A_1234;
    signed_i = ~s;
    seen      = 1'b0;
    ready_bad = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (v_o) begin
        seen = 1'b1;
        break;
      end
      if (ready_o) ready_bad = 1'b1;
      // A request while busy must be ignored.
      if (k == 5) v_i = 1'b1;
      if (k == 6) v_i = 1'b0;
    end
    v_i = 1'b0;
    check({tag, " latency"}, seen ? 64'(k - 1) : 64'd999, 64'd32);
    check({tag, " ready_busy"}, {63'b0, ready_bad}, 64'd0);
    check({tag, " ready_and_v"}, {63'b0, ready_o & v_o}, 64'd0);
    check({tag, " product"}, {hi_o, lo_o}, exp);
    if (hold > 0) begin
      repeat (hold) @(negedge clk_i);
      check({tag, " hold_v"}, {63'b0, v_o}, 64'd1);
      check({tag, " hold_product"}, {hi_o, lo_o}, exp);
    end
    yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    yumi_i = 1'b0;
    @(negedge clk_i);
    check({tag, " ready_after_yumi"}, {62'b0, ready_o, v_o}, 64'd2);
    check({tag, " kept_after_yumi"}, {hi_o, lo_o}, exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    reset_n_i = 1'b0;
    signed_i  = 1'b0;
    v_i       = 1'b0;
    a_i       = '0;
    b_i       = '0;
    yumi_i    = 1'b0;
    #12;
    check("reset_state", {30'b0, ready_o, v_o, hi_o, lo_o}, {30'b0, 2'b10, 64'd0});
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    // yumi while idle must do nothing.
    yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
    check("yumi_idle", {62'b0, ready_o, v_o}, 64'd2);

    // -7 * 6 with a stalled consumer.
    run_op(32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 10, "neg7x6");

    // Asynchronous reset during CALC discards the operation.
    v_i = 1'b1; a_i = 32'd5; b_i = 32'd9; signed_i = 1'b0;
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
    repeat (10) @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_reset", {30'b0, ready_o, v_o, hi_o, lo_o}, {30'b0, 2'b10, 64'd0});
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    run_op(32'd3, 32'd4, 1'b0, 64'd12, 0, "3x4_after_reset");

    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, "min_x_min");
    run_op(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 0, "min_x_1");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, "ones_unsigned");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, 0, "ones_signed");
    run_op(32'd0, 32'h1234_5678, 1'b1, 64'd0, 0, "zero_signed");

    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 8 == 3) ra = '0;
      if (i % 8 == 6) rb = '0;
      run_op(ra, rb, rs, ref_mul(ra, rb, rs), 0, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
